// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between the MEM stage and data memory: in-order
// retirement, youngest-match load forwarding, full/fence stall generation.
module mem_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic              FenceM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              BufEmpty,
    output logic              DMWriteEn,
    output logic [ADDR_W-1:0] DMAddr,
    output logic [DATA_W-1:0] DMWriteData,
    input  logic              DMReady,
    input  logic [DATA_W-1:0] DMReadData
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              empty_c;
    logic              full_c;
    logic              enq_c;
    logic              pop_c;
    logic              fwd_hit_c;
    logic [DATA_W-1:0] fwd_data_c;
    logic [PTR_W-1:0]  scan_idx_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNT_W'(DEPTH));

    // Full stall holds even when a pop frees a slot this cycle; the store retries.
    assign StallM = (full_c && MemWriteM) || (FenceM && !empty_c);
    assign enq_c  = MemWriteM && !StallM && (ALUResultM != '0);
    assign pop_c  = !empty_c && DMReady;

    assign BufEmpty    = empty_c;
    assign DMWriteEn   = !empty_c;
    assign DMAddr      = empty_c ? '0 : addr_q[head_q];
    assign DMWriteData = empty_c ? '0 : data_q[head_q];

    // Scan oldest to youngest so the last hit wins; the popping head still counts.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        scan_idx_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx_c = head_q + PTR_W'(i);
            if (valid_q[scan_idx_c] && (addr_q[scan_idx_c] == ALUResultM)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = data_q[scan_idx_c];
            end
        end
    end

    assign ReadDataM = (MemReadM && !MemWriteM && fwd_hit_c && (ALUResultM != '0))
                       ? fwd_data_c : DMReadData;

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_c) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (enq_c) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (enq_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !enq_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq_c) begin
                addr_q[tail_q] <= ALUResultM;
                data_q[tail_q] <= WriteDataM;
            end
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: vector table plus hand sequences, with a queue
// scoreboard checking drain order and data of every memory write.
module tb_mem_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWriteM, MemReadM, FenceM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, BufEmpty, DMWriteEn;
    logic [31:0] DMAddr, DMWriteData;
    logic        DMReady;
    logic [31:0] DMReadData;

    mem_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemWriteM(MemWriteM), .MemReadM(MemReadM), .FenceM(FenceM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .BufEmpty(BufEmpty),
        .DMWriteEn(DMWriteEn), .DMAddr(DMAddr), .DMWriteData(DMWriteData),
        .DMReady(DMReady), .DMReadData(DMReadData)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        we, re, fe;
        logic [31:0] addr, wdata;
        logic        rdy;
        logic [31:0] dmrd;
        logic        exp_stall;
        logic [31:0] exp_rd;
    } vec_t;

    ent_t sb[$];
    vec_t vt[30];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, re, fe, input logic [31:0] a, wd,
                                input logic rdy, input logic [31:0] dmrd,
                                input logic st, input logic [31:0] rd);
        vec_t v;
        v.we = we; v.re = re; v.fe = fe; v.addr = a; v.wdata = wd;
        v.rdy = rdy; v.dmrd = dmrd; v.exp_stall = st; v.exp_rd = rd;
        return v;
    endfunction

    // One cycle: drive after negedge, check before the next posedge, update scoreboard.
    task automatic step(input vec_t v, input string tag);
        ent_t e;
        @(negedge clk);
        MemWriteM = v.we; MemReadM = v.re; FenceM = v.fe;
        ALUResultM = v.addr; WriteDataM = v.wdata;
        DMReady = v.rdy; DMReadData = v.dmrd;
        #2;
        chk({tag, ".stall"}, 32'(StallM), 32'(v.exp_stall));
        chk({tag, ".empty"}, 32'(BufEmpty), 32'(sb.size() == 0));
        chk({tag, ".dmwe"}, 32'(DMWriteEn), 32'(sb.size() != 0));
        if (v.re) chk({tag, ".rdata"}, ReadDataM, v.exp_rd);
        if (DMWriteEn && v.rdy) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL %s.spurious_write: got addr 0x%08h expected no write", tag, DMAddr);
            end else begin
                e = sb.pop_front();
                chk({tag, ".dmaddr"}, DMAddr, e.a);
                chk({tag, ".dmdata"}, DMWriteData, e.d);
            end
        end
        if (v.we && !v.exp_stall && v.addr != 32'd0) sb.push_back('{a: v.addr, d: v.wdata});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single store, forwarding, address 0, fence, fill/stall/retry.
        vt[0]  = mk(1,0,0, 32'd8, 32'hDEADBEEF, 1, 0, 0, 0);
        vt[1]  = mk(0,0,0, 0, 0, 1, 0, 0, 0);
        vt[2]  = mk(0,0,0, 0, 0, 1, 0, 0, 0);
        vt[3]  = mk(1,0,0, 32'd5, 32'h11, 0, 0, 0, 0);
        vt[4]  = mk(1,0,0, 32'd5, 32'h22, 0, 0, 0, 0);
        vt[5]  = mk(0,1,0, 32'd5, 0, 0, 32'h99, 0, 32'h22);
        vt[6]  = mk(0,1,0, 32'd6, 0, 0, 32'h77, 0, 32'h77);
        vt[7]  = mk(0,1,0, 32'd0, 0, 0, 32'h66, 0, 32'h66);
        vt[8]  = mk(0,1,0, 32'd5, 0, 1, 32'h99, 0, 32'h22);
        vt[9]  = mk(0,1,0, 32'd5, 0, 1, 32'h99, 0, 32'h22);
        vt[10] = mk(0,1,0, 32'd5, 0, 1, 32'h99, 0, 32'h99);
        vt[11] = mk(1,0,0, 32'd0, 32'h55, 1, 0, 0, 0);
        vt[12] = mk(0,0,0, 0, 0, 1, 0, 0, 0);
        vt[13] = mk(1,0,0, 32'd10, 32'hA0, 0, 0, 0, 0);
        vt[14] = mk(1,0,0, 32'd11, 32'hB0, 0, 0, 0, 0);
        vt[15] = mk(0,0,1, 0, 0, 1, 0, 1, 0);
        vt[16] = mk(0,0,1, 0, 0, 1, 0, 1, 0);
        vt[17] = mk(0,0,1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            vt[18+i] = mk(1,0,0, 32'(i+1), 32'(32'h100+i), 0, 0, 0, 0);
        vt[22] = mk(1,0,0, 32'd5, 32'h104, 0, 0, 1, 0);
        vt[23] = mk(1,0,0, 32'd5, 32'h104, 0, 0, 1, 0);
        vt[24] = mk(1,0,0, 32'd5, 32'h104, 1, 0, 1, 0);
        vt[25] = mk(1,0,0, 32'd5, 32'h104, 1, 0, 0, 0);
        for (int i = 26; i < 30; i++) vt[i] = mk(0,0,0, 0, 0, 1, 0, 0, 0);

        rst_n = 1'b0;
        MemWriteM = 0; MemReadM = 0; FenceM = 0;
        ALUResultM = 0; WriteDataM = 0; DMReady = 1; DMReadData = 32'hABCD;
        repeat (2) @(posedge clk);
        #2;
        chk("rst.empty", 32'(BufEmpty), 32'd1);
        chk("rst.dmwe", 32'(DMWriteEn), 32'd0);
        chk("rst.stall", 32'(StallM), 32'd0);
        chk("rst.dmaddr", DMAddr, 32'd0);
        chk("rst.rdata", ReadDataM, 32'hABCD);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) step(vt[i], $sformatf("vec%0d", i));
        chk("table.drained", 32'(sb.size()), 32'd0);

        // Steady enqueue+pop at count 3 across several pointer wraps.
        for (int k = 0; k < 3; k++)
            step(mk(1,0,0, 32'(32'h20+k), $urandom, 0, 0, 0, 0), "wrap.fill");
        for (int k = 3; k < 13; k++)
            step(mk(1,0,0, 32'(32'h20+k), $urandom, 1, 0, 0, 0), "wrap.steady");
        for (int k = 0; k < 4; k++)
            step(mk(0,0,0, 0, 0, 1, 0, 0, 0), "wrap.drain");
        chk("wrap.drained", 32'(sb.size()), 32'd0);

        // Reset with three entries held clears outputs without waiting for a clock.
        for (int k = 0; k < 3; k++)
            step(mk(1,0,0, 32'(32'h40+k), 32'(32'hC0+k), 0, 0, 0, 0), "rstmid.fill");
        @(negedge clk);
        MemWriteM = 0; DMReady = 1; DMReadData = 32'h1234;
        #1;
        chk("rstmid.pre_dmwe", 32'(DMWriteEn), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.empty", 32'(BufEmpty), 32'd1);
        chk("rstmid.dmwe", 32'(DMWriteEn), 32'd0);
        chk("rstmid.dmaddr", DMAddr, 32'd0);
        chk("rstmid.dmdata", DMWriteData, 32'd0);
        chk("rstmid.rdata", ReadDataM, 32'h1234);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(0,1,0, 32'h40, 0, 1, 32'h5678, 0, 32'h5678), "rstmid.after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
